// File: rtl/j1_uart.sv
// UART peripheral on the J1 I/O bus: 8-deep TX FIFO, single-byte RX holding
// register, status/control registers and a level interrupt.
module j1_uart #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [15:0] BASE_ADDR    = 16'h1000
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    output logic        interrupt_request,
    output logic        uart_tx,
    input  logic        uart_rx
);

    localparam logic [15:0] A_DATA = BASE_ADDR;
    localparam logic [15:0] A_STAT = BASE_ADDR + 16'd2;
    localparam logic [15:0] A_CTRL = BASE_ADDR + 16'd4;
    localparam logic [15:0] T_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] T_HALF = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic sel_data, sel_stat, sel_ctrl;
    logic rd_data, rd_stat, wr_data, wr_ctrl;
    logic unused_hi;

    assign sel_data  = (io_addr == A_DATA);
    assign sel_stat  = (io_addr == A_STAT);
    assign sel_ctrl  = (io_addr == A_CTRL);
    assign rd_data   = io_rd & sel_data;
    assign rd_stat   = io_rd & sel_stat;
    assign wr_data   = io_wr & sel_data;
    assign wr_ctrl   = io_wr & sel_ctrl;
    assign unused_hi = &{1'b0, io_dout[15:8]};

    logic [1:0] ctrl;

    // ---------------- TX FIFO ----------------
    logic [7:0] fifo [8];
    logic [2:0] wptr, rptr;
    logic [3:0] count, count_n;
    logic       tx_full, tx_empty, tx_idle, tx_pop, push;

    assign tx_full  = (count == 4'd8);
    assign tx_empty = (count == 4'd0);
    // A full FIFO still accepts a write when the shifter pops in the same cycle
    assign push     = wr_data & (~tx_full | tx_pop);

    always_comb begin
        count_n = count;
        if (push & ~tx_pop)
            count_n = count + 4'd1;
        else if (~push & tx_pop)
            count_n = count - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo[wptr] <= io_dout[7:0];
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + 3'd1;
            if (tx_pop)
                rptr <= rptr + 3'd1;
            count <= count_n;
        end
    end

    // ---------------- TX shifter ----------------
    tx_state_t   tx_state, tx_state_n;
    logic [15:0] tx_timer, tx_timer_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        tx_line_n, tx_tick;

    assign tx_tick = (tx_timer == T_LAST);
    assign tx_idle = tx_empty & (tx_state == TX_IDLE);

    always_comb begin
        tx_state_n = tx_state;
        tx_timer_n = tx_timer + 16'd1;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_line_n  = uart_tx;
        tx_pop     = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                tx_line_n = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = fifo[rptr];
                    tx_timer_n = '0;
                    tx_line_n  = 1'b0;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_timer_n = '0;
                    tx_bit_n   = '0;
                    tx_line_n  = tx_shift[0];
                    tx_state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    tx_timer_n = '0;
                    if (tx_bit == 3'd7) begin
                        tx_line_n  = 1'b1;
                        tx_state_n = TX_STOP;
                    end else begin
                        tx_bit_n   = tx_bit + 3'd1;
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                        tx_line_n  = tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    tx_timer_n = '0;
                    // Chain straight into the next start bit: no idle gap
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_n = fifo[rptr];
                        tx_line_n  = 1'b0;
                        tx_state_n = TX_START;
                    end else begin
                        tx_line_n  = 1'b1;
                        tx_state_n = TX_IDLE;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state <= TX_IDLE;
            tx_timer <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_timer <= tx_timer_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            uart_tx  <= tx_line_n;
        end
    end

    // ---------------- RX ----------------
    logic [1:0]  rx_sync;
    logic        rx_s, rx_prev;
    rx_state_t   rx_state, rx_state_n;
    logic [15:0] rx_timer, rx_timer_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n, rx_byte;
    logic        rx_done, rx_bad;
    logic        rx_valid, rx_overrun, rx_frame_err;

    assign rx_s = rx_sync[1];

    always_comb begin
        rx_state_n = rx_state;
        rx_timer_n = rx_timer + 16'd1;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_done    = 1'b0;
        rx_bad     = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                if (rx_prev & ~rx_s) begin
                    rx_timer_n = '0;
                    rx_state_n = RX_START;
                end
            end
            RX_START: begin
                if (rx_timer == T_HALF) begin
                    rx_timer_n = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_timer == T_LAST) begin
                    rx_timer_n = '0;
                    rx_shift_n = {rx_s, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7)
                        rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_timer == T_LAST) begin
                    rx_done    = rx_s;
                    rx_bad     = ~rx_s;
                    rx_state_n = RX_IDLE;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_sync      <= 2'b11;
            rx_prev      <= 1'b1;
            rx_state     <= RX_IDLE;
            rx_timer     <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_sync      <= {rx_sync[0], uart_rx};
            rx_prev      <= rx_s;
            rx_state     <= rx_state_n;
            rx_timer     <= rx_timer_n;
            rx_bit       <= rx_bit_n;
            rx_shift     <= rx_shift_n;
            if (rx_done)
                rx_byte <= rx_shift;
            rx_valid     <= rx_done | (rx_valid & ~rd_data);
            // A byte landing on the edge it is read is not an overrun
            rx_overrun   <= (rx_done & rx_valid & ~rd_data)
                          | (rx_overrun & ~rd_stat);
            rx_frame_err <= rx_bad | (rx_frame_err & ~rd_stat);
        end
    end

    // ---------------- Control, interrupt, read mux ----------------
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            ctrl              <= '0;
            interrupt_request <= 1'b0;
        end else begin
            if (wr_ctrl)
                ctrl <= io_dout[1:0];
            interrupt_request <= (ctrl[0] & rx_valid) | (ctrl[1] & tx_idle);
        end
    end

    always_comb begin
        io_din = 16'h0000;
        if (io_rd) begin
            unique case (1'b1)
                sel_data: io_din = rx_valid ? {8'h00, rx_byte} : 16'h0000;
                sel_stat: io_din = {11'd0, rx_frame_err, rx_overrun,
                                    rx_valid, tx_idle, tx_full};
                sel_ctrl: io_din = {14'd0, ctrl};
                default:  io_din = 16'h0000;
            endcase
        end
    end

endmodule
